// File: rtl/perm_round_engine_if.sv
// Handshake/data bundle between the upstream XOR stage, the permutation engine and
// the downstream XOR/tag stage.
interface perm_round_engine_if;
  logic         start_i;
  logic         mode_pb_i;
  logic [319:0] state_i;
  logic [319:0] state_o;
  logic         busy_o;
  logic         done_o;

  modport master (
    output start_i, mode_pb_i, state_i,
    input  state_o, busy_o, done_o
  );

  modport slave (
    input  start_i, mode_pb_i, state_i,
    output state_o, busy_o, done_o
  );
endinterface

// File: rtl/perm_round_engine.sv
// Iterative Ascon permutation: one round per clock, p^a (rounds 0..PA-1) or
// p^b (rounds PA-PB..PA-1), result held on state_o after a one-cycle done pulse.
module perm_round_engine #(
  parameter int unsigned PA_ROUNDS = 12,
  parameter int unsigned PB_ROUNDS = 6
) (
  input logic             clock_i,
  input logic             resetb_i,
  perm_round_engine_if.slave bus
);

  localparam logic [3:0] PbStart   = 4'(PA_ROUNDS - PB_ROUNDS);
  localparam logic [3:0] LastRound = 4'(PA_ROUNDS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e       fsm_q, fsm_d;
  logic [319:0] state_q, state_d;
  logic [319:0] round_in, round_out;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   round_idx;
  logic         done_q, done_d;
  logic         load;
  logic         last;

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // Constant addition, bitsliced S-box layer, linear diffusion.
  function automatic logic [319:0] round_fn(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [3:0]  rc_hi;
    rc_hi = 4'(4'd15 - r);
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128] ^ {56'd0, rc_hi, r};
    x3 = s[127:64];
    x4 = s[63:0];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  assign round_out = round_fn(round_in, round_idx);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load) begin
      fsm_d   = last ? StIdle : StRun;
      state_d = round_out;
      cnt_d   = round_idx + 4'd1;
      done_d  = last;
    end
  end

  // In IDLE the round input comes straight from upstream so the first round
  // lands on the start edge itself.
  always_comb begin
    load      = 1'b0;
    round_in  = state_q;
    round_idx = cnt_q;
    unique case (fsm_q)
      StIdle: begin
        load      = bus.start_i;
        round_in  = bus.state_i;
        round_idx = bus.mode_pb_i ? PbStart : 4'd0;
      end
      StRun:   load = 1'b1;
      default: load = 1'b0;
    endcase
    last        = (round_idx == LastRound);
    bus.busy_o  = (fsm_q == StRun);
    bus.done_o  = done_q;
    bus.state_o = state_q;
  end

endmodule

// File: tb/tb_perm_round_engine.sv
// Randomized bench for perm_round_engine against a table-driven Ascon reference model.
module tb_perm_round_engine;

  logic clock_i;
  logic resetb_i;
  int   checks;
  int   errors;

  perm_round_engine_if bus_if ();

  perm_round_engine #(
    .PA_ROUNDS(12),
    .PB_ROUNDS(6)
  ) u_dut (
    .clock_i (clock_i),
    .resetb_i(resetb_i),
    .bus     (bus_if)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [63:0] model_ror(input logic [63:0] x, input int n);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[i] = x[(i + n) % 64];
    return y;
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64 * i -: 64];
    x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) * 16) + r);
    for (int b = 0; b < 64; b++) begin
      v = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
      for (int i = 0; i < 5; i++) y[i][b] = v[4 - i];
    end
    x[0] = y[0] ^ model_ror(y[0], 19) ^ model_ror(y[0], 28);
    x[1] = y[1] ^ model_ror(y[1], 61) ^ model_ror(y[1], 39);
    x[2] = y[2] ^ model_ror(y[2], 1)  ^ model_ror(y[2], 6);
    x[3] = y[3] ^ model_ror(y[3], 10) ^ model_ror(y[3], 17);
    x[4] = y[4] ^ model_ror(y[4], 7)  ^ model_ror(y[4], 41);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[32 * i +: 32] = $urandom;
    return s;
  endfunction

  task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [319:0] exp_state);
    check_val({tag, " state"}, bus_if.state_o, exp_state);
    check_val({tag, " busy"}, 320'(bus_if.busy_o), 320'(0));
    check_val({tag, " done"}, 320'(bus_if.done_o), 320'(0));
  endtask

  // Called just after an edge; the following edge is the start edge.
  task automatic start_run(input logic [319:0] s, input bit pb);
    bus_if.start_i   = 1'b1;
    bus_if.state_i   = s;
    bus_if.mode_pb_i = pb;
  endtask

  // Walks a run edge by edge. inject: foreign starts before E3 and E7.
  // chain: start held in the done cycle with state s2 (p^a).
  task automatic follow_run(input string tag, input logic [319:0] s, input bit pb,
                            input bit inject, input bit chain, input logic [319:0] s2,
                            output logic [319:0] result);
    int n;
    int first;
    logic [319:0] exp;
    n     = pb ? 6 : 12;
    first = pb ? 6 : 0;
    exp   = s;
    for (int k = 0; k < n; k++) begin
      @(posedge clock_i);
      #1;
      exp = model_round(exp, first + k);
      check_val($sformatf("%s r%0d state", tag, first + k), bus_if.state_o, exp);
      check_val($sformatf("%s e%0d busy", tag, k), 320'(bus_if.busy_o), 320'(k < n - 1));
      check_val($sformatf("%s e%0d done", tag, k), 320'(bus_if.done_o), 320'(k == n - 1));
      bus_if.start_i   = 1'b0;
      bus_if.state_i   = rand_state();
      bus_if.mode_pb_i = 1'($urandom);
      if (inject && (k == 2 || k == 6)) begin
        bus_if.start_i = 1'b1;
      end else if (chain && k == n - 1) begin
        bus_if.start_i   = 1'b1;
        bus_if.state_i   = s2;
        bus_if.mode_pb_i = 1'b0;
      end
    end
    result = exp;
    if (!chain) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clock_i);
        #1;
        check_idle_outputs($sformatf("%s hold%0d", tag, k), exp);
        bus_if.state_i = rand_state();
      end
    end
  endtask

  logic [319:0] init_state;
  logic [319:0] s_a;
  logic [319:0] s_b;
  logic [319:0] res;

  initial begin
    checks           = 0;
    errors           = 0;
    resetb_i         = 1'b0;
    bus_if.start_i   = 1'b0;
    bus_if.mode_pb_i = 1'b0;
    bus_if.state_i   = '0;
    init_state = {64'h80400C0600000000, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
                  64'h0001020304050607, 64'h08090A0B0C0D0E0F};

    // Reset, then a long idle stretch.
    repeat (3) @(posedge clock_i);
    #1;
    check_idle_outputs("reset", '0);
    resetb_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock_i);
      #1;
      check_idle_outputs($sformatf("idle%0d", k), '0);
      bus_if.state_i = rand_state();
    end

    start_run(init_state, 1'b0);
    follow_run("pa_init", init_state, 1'b0, 1'b0, 1'b0, '0, res);

    start_run(init_state, 1'b1);
    follow_run("pb_init", init_state, 1'b1, 1'b0, 1'b0, '0, res);

    start_run('0, 1'b1);
    follow_run("pb_zero", '0, 1'b1, 1'b0, 1'b0, '0, res);

    s_a = rand_state();
    start_run(s_a, 1'b0);
    follow_run("busy_ign", s_a, 1'b0, 1'b1, 1'b0, '0, res);

    s_a = rand_state();
    s_b = rand_state();
    start_run(s_a, 1'b0);
    follow_run("b2b_1", s_a, 1'b0, 1'b0, 1'b1, s_b, res);
    follow_run("b2b_2", s_b, 1'b0, 1'b0, 1'b0, '0, res);

    for (int t = 0; t < 4; t++) begin
      bit pb;
      pb  = 1'($urandom);
      s_a = rand_state();
      start_run(s_a, pb);
      follow_run($sformatf("rnd%0d", t), s_a, pb, 1'b0, 1'b0, '0, res);
    end

    // Asynchronous reset between edges after E5 of a p^a run.
    s_a = rand_state();
    start_run(s_a, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clock_i);
      #1;
      bus_if.start_i = 1'b0;
    end
    #2;
    resetb_i = 1'b0;
    #1;
    check_idle_outputs("midrst", '0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock_i);
      #1;
      check_idle_outputs($sformatf("midrst_hold%0d", k), '0);
    end
    resetb_i = 1'b1;
    s_b = rand_state();
    start_run(s_b, 1'b0);
    follow_run("after_rst", s_b, 1'b0, 1'b0, 1'b0, '0, res);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
